// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the push arbiter.
package fifo_arb_pkg;

  localparam int unsigned RR_MAX_REQ  = 32;
  localparam int unsigned RR_MAX_ID_W = 5;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  typedef struct packed {
    logic                   found;
    logic [RR_MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First valid index searching ptr..n-1, then wrapping to 0..ptr-1.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input int unsigned            ptr,
                                       input int unsigned            n);
    rr_pick_t res;
    res = '0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      if (!res.found && valid[i] && (i >= ptr) && (i < n)) begin
        res.found = 1'b1;
        res.idx   = RR_MAX_ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      if (!res.found && valid[i] && (i < ptr) && (i < n)) begin
        res.found = 1'b1;
        res.idx   = RR_MAX_ID_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, registered head (optional fall-through), async active-low reset.
// Writes while full and reads while empty are dropped; flush clears pointers and count.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] r_rd_ptr;
  logic [ADDR_DEPTH-1:0] r_wr_ptr;
  logic [ADDR_DEPTH:0]   r_cnt;
  dtype                  r_mem [DEPTH];
  logic                  w_bypass;
  logic                  w_wr;
  logic                  w_rd;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o   = (r_cnt == FULL_CNT);
  assign empty_o  = (r_cnt == '0) && !(FALL_THROUGH && push_i);
  assign usage_o  = r_cnt[ADDR_DEPTH-1:0];
  assign w_bypass = FALL_THROUGH && (r_cnt == '0) && push_i && pop_i;
  assign w_wr     = push_i && !full_o && !w_bypass;
  assign w_rd     = pop_i && !empty_o && !w_bypass;
  assign data_o   = (FALL_THROUGH && (r_cnt == '0)) ? data_i : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_full_write: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  a_empty_read: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_ptr, wrapping.
module rr_arbiter import fifo_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx
);

  rr_pick_t w_pick;

  always_comb w_pick = rr_pick(RR_MAX_REQ'(i_valid), 32'(i_ptr), NUM_REQ);

  assign o_found = w_pick.found;
  assign o_idx   = ID_W'(w_pick.idx);

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ push ports into one id-tagged fifo_v3; 1-cycle push-to-head.
// Ready is one-hot (or zero), gated by fifo full with no same-cycle pop bypass, and forced low on flush.
module fifo_push_arbiter import fifo_arb_pkg::*; #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          testmode_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [ID_W-1:0]               out_id_o,
  input  logic                          out_ready_i,
  output logic [ADDR_DEPTH-1:0]         usage_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef logic [ID_W+DATA_WIDTH-1:0] entry_t;

  arb_state_e       r_state;
  arb_state_e       w_state_d;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_rr_ptr_d;
  logic [ID_W-1:0]  r_owner;
  logic [ID_W-1:0]  w_owner_d;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_d;

  logic             w_found;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_id;
  logic [ID_W-1:0]  w_ptr_inc;
  logic             w_accept;
  logic             w_last;
  logic             w_full;
  logic             w_empty;
  entry_t           w_push_dat;
  entry_t           w_head;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_valid (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_winner)
  );

  // While locked the owner keeps the port even when it drops valid.
  assign w_id       = (r_state == LOCKED) ? r_owner : w_winner;
  assign w_ptr_inc  = ID_W'((32'(w_id) + 32'd1) % NUM_REQ);
  assign w_last     = req_last_i[w_id];
  assign w_accept   = |(req_valid_i & req_ready_o);
  assign w_push_dat = {w_id, req_data_i[w_id*DATA_WIDTH +: DATA_WIDTH]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_owner     <= w_owner_d;
      r_burst_cnt <= w_burst_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_owner_d     = r_owner;
    w_burst_cnt_d = r_burst_cnt;
    if (flush_i) begin
      w_state_d     = IDLE;
      w_rr_ptr_d    = '0;
      w_owner_d     = '0;
      w_burst_cnt_d = '0;
    end else if (w_accept) begin
      unique case (r_state)
        IDLE: begin
          if (w_last || (MAX_BURST == 1)) begin
            w_rr_ptr_d = w_ptr_inc;
          end else begin
            w_state_d     = LOCKED;
            w_owner_d     = w_winner;
            w_burst_cnt_d = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (w_last || ((32'(r_burst_cnt) + 32'd1) == MAX_BURST)) begin
            w_state_d     = IDLE;
            w_rr_ptr_d    = w_ptr_inc;
            w_burst_cnt_d = '0;
          end else begin
            w_burst_cnt_d = r_burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (((r_state == LOCKED) || w_found) && !w_full && !flush_i) req_ready_o[w_id] = 1'b1;
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (ID_W + DATA_WIDTH),
    .DEPTH        (DEPTH),
    .dtype        (entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .testmode_i (testmode_i),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .usage_o    (usage_o),
    .data_i     (w_push_dat),
    .push_i     (w_accept),
    .data_o     (w_head),
    .pop_i      (out_valid_o & out_ready_i)
  );

  assign out_valid_o = !w_empty;
  assign out_data_o  = w_head[DATA_WIDTH-1:0];
  assign out_id_o    = w_head[ID_W+DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: hand-ordered expected beats go into a scoreboard queue, a negedge monitor checks pops.
module tb_fifo_push_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         testmode;
  logic         out_ready;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic [2:0]   usage;

  fifo_push_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .MAX_BURST  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .testmode_i  (testmode),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_id_o    (out_id),
    .out_ready_i (out_ready),
    .usage_o     (usage)
  );

  always #5 clk = ~clk;

  logic [32:0] pq [4][$];
  logic [33:0] exp_q [$];
  logic [33:0] mon_e;
  logic [3:0]  vmask;
  logic [3:0]  s_rdy;
  logic        s_ov;
  logic [2:0]  s_usage;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] dat(input int p, input int b);
    return 32'((p << 24) | 32'h005A_0000 | b);
  endfunction

  task automatic add(input int p, input int b, input logic last);
    pq[p].push_back({last, dat(p, b)});
  endtask

  task automatic expect_beat(input int p, input int b);
    exp_q.push_back({2'(p), dat(p, b)});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    logic [32:0] hd;
    for (int p = 0; p < 4; p++) begin
      if (pq[p].size() != 0 && vmask[p]) begin
        hd = pq[p][0];
        req_valid[p]            = 1'b1;
        req_last[p]             = hd[32];
        req_data[p*32 +: 32]    = hd[31:0];
      end else begin
        req_valid[p]            = 1'b0;
        req_last[p]             = 1'b0;
        req_data[p*32 +: 32]    = '0;
      end
    end
  endtask

  // One clock: sample at negedge, retire accepted beats after the posedge.
  task automatic cycle();
    logic [3:0] acc;
    drive();
    @(negedge clk);
    s_rdy   = req_ready;
    s_ov    = out_valid;
    s_usage = usage;
    acc     = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) if (acc[p]) void'(pq[p].pop_front());
    drive();
  endtask

  task automatic run_rdy(input string nm, input logic [3:0] exp);
    cycle();
    chk(nm, 32'(s_rdy), 32'(exp));
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < 4; p++) s += pq[p].size();
    return s;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || pending() != 0) && n < 200) begin
      cycle();
      n++;
    end
    chk({nm, "_left"}, 32'(exp_q.size() + pending()), 32'd0);
    repeat (2) cycle();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_beat: got id=%0d data=%h, expected no beat", out_id, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_id, out_data} !== mon_e) begin
          n_err++;
          $display("FAIL out_beat: got id=%0d data=%h, expected id=%0d data=%h",
                   out_id, out_data, mon_e[33:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; testmode = 1'b0; out_ready = 1'b0;
    vmask = 4'hF; req_valid = '0; req_last = '0; req_data = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_usage", 32'(usage), 32'd0);
    @(posedge clk); #1;

    // 1: every beat is last -> plain round robin 0,1,2,3,0
    for (int p = 0; p < 4; p++) add(p, 0, 1'b1);
    add(0, 1, 1'b1);
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 0); expect_beat(0, 1);
    out_ready = 1'b1;
    cycle();
    chk("t1_rdy0", 32'(s_rdy), 32'b0001);
    chk("t1_ov_latency0", 32'(s_ov), 32'd0);
    cycle();
    chk("t1_rdy1", 32'(s_rdy), 32'b0010);
    chk("t1_ov_latency1", 32'(s_ov), 32'd1);
    run_rdy("t1_rdy2", 4'b0100);
    run_rdy("t1_rdy3", 4'b1000);
    run_rdy("t1_rdy4", 4'b0001);
    drain("t1");

    // 2: req1 six-beat burst split at MAX_BURST, req2 slips in between
    for (int b = 0; b < 6; b++) add(1, b, b == 5);
    add(2, 0, 1'b1);
    for (int b = 0; b < 4; b++) expect_beat(1, b);
    expect_beat(2, 0); expect_beat(1, 4); expect_beat(1, 5);
    repeat (4) run_rdy("t2_burst_a", 4'b0010);
    run_rdy("t2_req2", 4'b0100);
    repeat (2) run_rdy("t2_burst_b", 4'b0010);
    drain("t2");

    // 3: locked owner drops valid; req3 must stall
    for (int b = 0; b < 4; b++) add(0, b, b == 3);
    add(3, 0, 1'b1);
    for (int b = 0; b < 4; b++) expect_beat(0, b);
    expect_beat(3, 0);
    vmask = 4'b0001;
    run_rdy("t3_first", 4'b0001);
    vmask = 4'b1000;
    repeat (3) run_rdy("t3_stall", 4'b0001);
    vmask = 4'b1001;
    repeat (3) run_rdy("t3_resume", 4'b0001);
    run_rdy("t3_next", 4'b1000);
    drain("t3");

    // 4: fill to DEPTH, no same-cycle bypass on pop
    out_ready = 1'b0;
    vmask = 4'b0100;
    for (int b = 0; b < 10; b++) begin add(2, b, 1'b1); expect_beat(2, b); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t4_fill", 32'(s_rdy), 32'b0100);
      if (i == 7) chk("t4_usage7", 32'(s_usage), 32'd7);
    end
    run_rdy("t4_full", 4'b0000);
    out_ready = 1'b1;
    run_rdy("t4_pop_cycle", 4'b0000);
    out_ready = 1'b0;
    run_rdy("t4_refill", 4'b0100);
    run_rdy("t4_full_again", 4'b0000);
    drain("t4");

    // 5: flush mid-burst with five entries queued
    out_ready = 1'b0;
    vmask = 4'b0010;
    for (int b = 0; b < 8; b++) add(1, b, b == 7);
    add(0, 0, 1'b1);
    expect_beat(0, 0); expect_beat(1, 5); expect_beat(1, 6); expect_beat(1, 7);
    repeat (5) run_rdy("t5_fill", 4'b0010);
    flush = 1'b1;
    cycle();
    chk("t5_flush_rdy", 32'(s_rdy), 32'd0);
    chk("t5_usage5", 32'(s_usage), 32'd5);
    flush = 1'b0;
    vmask = 4'b0011;
    cycle();
    chk("t5_after_rdy", 32'(s_rdy), 32'b0001);
    chk("t5_after_ov", 32'(s_ov), 32'd0);
    chk("t5_after_usage", 32'(s_usage), 32'd0);
    drain("t5");

    // 6: async reset mid-burst
    out_ready = 1'b0;
    vmask = 4'b1000;
    for (int b = 0; b < 6; b++) add(3, b, b == 5);
    repeat (2) run_rdy("t6_burst", 4'b1000);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", 32'(out_valid), 32'd0);
    chk("t6_rst_usage", 32'(usage), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t6_hold_usage", 32'(usage), 32'd0);
    end
    vmask = 4'b0000;
    drive();
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", 32'(req_ready), 32'd0);
    chk("t6_rel_ov", 32'(out_valid), 32'd0);
    chk("t6_rel_data", out_data, 32'd0);
    chk("t6_rel_id", 32'(out_id), 32'd0);
    chk("t6_rel_usage", 32'(usage), 32'd0);
    for (int p = 0; p < 4; p++) pq[p].delete();
    add(0, 9, 1'b1); add(3, 9, 1'b1);
    expect_beat(0, 9); expect_beat(3, 9);
    vmask = 4'b1001;
    @(posedge clk); #1;
    run_rdy("t6_ptr_reset", 4'b0001);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
